// File: rtl/iq_readout_decimator_pkg.sv
// Shared definitions for the I/Q readout decimator.
// The ternary feedback encoding (POS/NEG) matches the wavelet core's
// feedback pulse lines. Also carries the default window size and the
// output buffer state type.
package iq_readout_decimator_pkg;

  localparam logic [1:0] POS = 2'b01;   // positive feedback pulse
  localparam logic [1:0] NEG = 2'b10;   // negative feedback pulse

  localparam int WIN_LOG2_DEF = 4;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  // Ternary decode: 01 -> +1, 10 -> -1, 00/11 -> 0.
  function automatic logic [1:0] decode_sel(input logic [1:0] raw);
    return (raw == POS) ? 2'b01 : (raw == NEG) ? 2'b11 : 2'b00;
  endfunction

endpackage

// File: rtl/iq_readout_decimator_chan_accum.sv
// iq_chan_accum: one channel's ternary decode plus window accumulator.
// Ports:
//   clk_master, rstb  clock / synchronous active-low reset
//   sample_en         take one sample this cycle
//   clear, complete   either one loads the accumulator with zero
//   raw               2-bit feedback pulse pair (bit0 pos, bit1 neg)
//   sum_next          acc + decoded sample (the window sum on completion)
module iq_chan_accum
  import iq_readout_decimator_pkg::*;
#(
  parameter int ACC_W = WIN_LOG2_DEF + 2
) (
  input  logic                    clk_master,
  input  logic                    rstb,
  input  logic                    sample_en,
  input  logic                    clear,
  input  logic                    complete,
  input  logic [1:0]              raw,
  output logic signed [ACC_W-1:0] sum_next
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] dec;
  logic [1:0]              sel;

  always_comb begin
    sel = decode_sel(raw);
    dec = '0;
    if (sel == 2'b01)      dec = ACC_W'(1);
    else if (sel == 2'b11) dec = '1;          // -1
    sum_next = acc + dec;
  end

  always_ff @(posedge clk_master) begin
    if (!rstb)                  acc <= '0;
    else if (clear || complete) acc <= '0;
    else if (sample_en)         acc <= sum_next;
  end

endmodule

// File: rtl/iq_readout_decimator.sv
// iq_readout_decimator: integrates ternary I/Q feedback pulses over
// 2^WIN_LOG2 samples and presents one result per window through a
// single-entry valid/ready buffer.
// Ports:
//   clk_master, rstb          clock / synchronous active-low reset
//   sample_en                 sample strobe
//   clear                     restart the current window (buffer untouched)
//   read_out_I, read_out_Q    feedback pulse pairs
//   out_valid, out_ready      result handshake
//   out_i, out_q              signed window sums
//   out_mag                   |I|+|Q|, only built with IQ_READOUT_MAG_EN,
//                             otherwise constant 0
//   overrun                   sticky, a result was overwritten unconsumed
module iq_readout_decimator
  import iq_readout_decimator_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int ACC_W    = WIN_LOG2 + 2
) (
  input  logic                    clk_master,
  input  logic                    rstb,
  input  logic                    sample_en,
  input  logic                    clear,
  input  logic [1:0]              read_out_I,
  input  logic [1:0]              read_out_Q,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_i,
  output logic signed [ACC_W-1:0] out_q,
  output logic [ACC_W-1:0]        out_mag,
  output logic                    overrun
);

  localparam int NUM_CH = 2;  // 0 = I, 1 = Q

  logic [WIN_LOG2-1:0]              cnt;
  logic                             complete;
  logic [NUM_CH-1:0][1:0]           raw;
  logic [NUM_CH-1:0][ACC_W-1:0]     sum;
  buf_state_e                       state;
  logic                             hs;

  assign raw      = {read_out_Q, read_out_I};
  // Clear beats a coincident completion: nothing is loaded.
  assign complete = sample_en && !clear && (&cnt);
  assign hs       = out_valid && out_ready;

  always_ff @(posedge clk_master) begin
    if (!rstb)          cnt <= '0;
    else if (clear)     cnt <= '0;
    else if (sample_en) cnt <= cnt + 1'b1;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    iq_chan_accum #(.ACC_W(ACC_W)) u_acc (
      .clk_master (clk_master),
      .rstb       (rstb),
      .sample_en  (sample_en),
      .clear      (clear),
      .complete   (complete),
      .raw        (raw[c]),
      .sum_next   (sum[c])
    );
  end

`ifdef IQ_READOUT_MAG_EN
  function automatic logic [ACC_W-1:0] abs_v(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] ? ACC_W'(-v) : ACC_W'(v);
  endfunction

  logic [ACC_W-1:0] mag_next;
  assign mag_next = abs_v(sum[0]) + abs_v(sum[1]);

  always_ff @(posedge clk_master) begin
    if (!rstb)         out_mag <= '0;
    else if (complete) out_mag <= mag_next;
  end
`else
  assign out_mag = '0;
`endif

  // Single-entry result buffer. A completion always loads newest data;
  // it only counts as an overrun if the old data was not taken this edge.
  always_ff @(posedge clk_master) begin
    if (!rstb) begin
      state     <= BUF_EMPTY;
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      overrun   <= 1'b0;
    end else begin
      if (complete) begin
        out_i <= sum[0];
        out_q <= sum[1];
      end
      case (state)
        BUF_EMPTY: begin
          if (complete) begin
            state     <= BUF_FULL;
            out_valid <= 1'b1;
          end
        end
        BUF_FULL: begin
          if (complete) begin
            if (!hs) overrun <= 1'b1;
          end else if (hs) begin
            state     <= BUF_EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= BUF_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iq_readout_decimator.sv
// Directed bench for iq_readout_decimator (WIN_LOG2=4, ACC_W=6).
// out_mag expectations follow IQ_READOUT_MAG_EN.
module tb_iq_readout_decimator;

  localparam int ACC_W = 6;

  logic              clk_master = 1'b0;
  logic              rstb       = 1'b0;
  logic              sample_en  = 1'b0;
  logic              clear      = 1'b0;
  logic [1:0]        read_out_I = 2'b00;
  logic [1:0]        read_out_Q = 2'b00;
  logic              out_ready  = 1'b0;
  logic              out_valid;
  logic signed [ACC_W-1:0] out_i;
  logic signed [ACC_W-1:0] out_q;
  logic [ACC_W-1:0]  out_mag;
  logic              overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk_master = ~clk_master;

  iq_readout_decimator dut (
    .clk_master (clk_master),
    .rstb       (rstb),
    .sample_en  (sample_en),
    .clear      (clear),
    .read_out_I (read_out_I),
    .read_out_Q (read_out_Q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_i      (out_i),
    .out_q      (out_q),
    .out_mag    (out_mag),
    .overrun    (overrun)
  );

  function automatic int mexp(input int m);
`ifdef IQ_READOUT_MAG_EN
    return m;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One clock: apply inputs, take the edge, settle 1 time unit past it.
  task automatic cyc(input logic en, input logic [1:0] i, input logic [1:0] q,
                     input logic clr, input logic rdy);
    sample_en  = en;
    read_out_I = i;
    read_out_Q = q;
    clear      = clr;
    out_ready  = rdy;
    @(posedge clk_master);
    #1;
  endtask

  task automatic run(input int n, input logic [1:0] i, input logic [1:0] q,
                     input logic rdy);
    for (int k = 0; k < n; k++) cyc(1'b1, i, q, 1'b0, rdy);
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    cyc(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    rstb = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_valid",   int'(out_valid), 0);
    check("rst_i",       int'(out_i), 0);
    check("rst_q",       int'(out_q), 0);
    check("rst_mag",     int'(out_mag), 0);
    check("rst_overrun", int'(overrun), 0);

    // Window of I=+1, Q=-1 with ready held high
    run(15, 2'b01, 2'b10, 1'b1);
    check("t1_valid_early", int'(out_valid), 0);
    run(1, 2'b01, 2'b10, 1'b1);
    check("t1_valid", int'(out_valid), 1);
    check("t1_i",     int'(out_i), 16);
    check("t1_q",     int'(out_q), -16);
    check("t1_mag",   int'(out_mag), mexp(32));
    cyc(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    check("t1_valid_drop", int'(out_valid), 0);

    // Alternating I, Q held 11 (still counts as a sample)
    for (int k = 0; k < 15; k++)
      cyc(1'b1, (k % 2 == 0) ? 2'b01 : 2'b10, 2'b11, 1'b0, 1'b1);
    check("t2_valid_early", int'(out_valid), 0);
    cyc(1'b1, 2'b10, 2'b11, 1'b0, 1'b1);
    check("t2_valid", int'(out_valid), 1);
    check("t2_i",     int'(out_i), 0);
    check("t2_q",     int'(out_q), 0);
    check("t2_mag",   int'(out_mag), mexp(0));
    cyc(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);

    // Overrun: two windows, consumer stalled
    run(16, 2'b01, 2'b00, 1'b0);
    check("t3_valid1", int'(out_valid), 1);
    check("t3_i1",     int'(out_i), 16);
    run(5, 2'b01, 2'b00, 1'b0);
    check("t3_hold_i", int'(out_i), 16);
    run(11, 2'b00, 2'b00, 1'b0);
    check("t3_valid2",  int'(out_valid), 1);
    check("t3_i2",      int'(out_i), 5);
    check("t3_mag2",    int'(out_mag), mexp(5));
    check("t3_overrun", int'(overrun), 1);
    cyc(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    check("t3_valid_drop",  int'(out_valid), 0);
    check("t3_overrun_stk", int'(overrun), 1);

    // Completion coincides with handshake of the prior result
    do_reset();
    check("t4_rst_overrun", int'(overrun), 0);
    run(16, 2'b10, 2'b00, 1'b0);
    check("t4_i1", int'(out_i), -16);
    run(15, 2'b01, 2'b01, 1'b0);
    run(1, 2'b01, 2'b01, 1'b1);
    check("t4_valid",   int'(out_valid), 1);
    check("t4_i2",      int'(out_i), 16);
    check("t4_q2",      int'(out_q), 16);
    check("t4_overrun", int'(overrun), 0);
    cyc(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    check("t4_valid_drop", int'(out_valid), 0);

    // Clear restarts the window
    run(10, 2'b01, 2'b00, 1'b1);
    cyc(1'b0, 2'b00, 2'b00, 1'b1, 1'b1);
    run(6, 2'b01, 2'b00, 1'b1);
    check("t5_no_early", int'(out_valid), 0);
    run(10, 2'b01, 2'b00, 1'b1);
    check("t5_valid", int'(out_valid), 1);
    check("t5_i",     int'(out_i), 16);
    cyc(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    run(15, 2'b01, 2'b00, 1'b1);
    cyc(1'b1, 2'b01, 2'b00, 1'b1, 1'b1);   // clear on the 16th sample
    check("t5_clr_no_result", int'(out_valid), 0);
    check("t5_clr_overrun",   int'(overrun), 0);
    run(16, 2'b10, 2'b00, 1'b1);
    check("t5_fresh_i", int'(out_i), -16);
    cyc(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);

    // Sparse strobes
    for (int k = 0; k < 15; k++) begin
      cyc(1'b1, 2'b10, 2'b00, 1'b0, 1'b1);
      cyc(1'b0, 2'b01, 2'b01, 1'b0, 1'b1);
      cyc(1'b0, 2'b01, 2'b01, 1'b0, 1'b1);
    end
    check("t6_valid_early", int'(out_valid), 0);
    cyc(1'b1, 2'b10, 2'b00, 1'b0, 1'b1);
    check("t6_valid", int'(out_valid), 1);
    check("t6_i",     int'(out_i), -16);
    check("t6_q",     int'(out_q), 0);
    check("t6_mag",   int'(out_mag), mexp(16));
    cyc(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);

    // Reset mid-window with buffer full and overrun set
    run(32, 2'b01, 2'b10, 1'b0);
    run(7, 2'b01, 2'b00, 1'b0);
    check("t7_pre_overrun", int'(overrun), 1);
    do_reset();
    check("t7_valid",   int'(out_valid), 0);
    check("t7_i",       int'(out_i), 0);
    check("t7_q",       int'(out_q), 0);
    check("t7_mag",     int'(out_mag), 0);
    check("t7_overrun", int'(overrun), 0);
    run(15, 2'b01, 2'b00, 1'b1);
    check("t7_valid_early", int'(out_valid), 0);
    run(1, 2'b01, 2'b00, 1'b1);
    check("t7_valid_new", int'(out_valid), 1);
    check("t7_i_new",     int'(out_i), 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
